// File: rtl/req_encoder16to4.sv
// Sticky 16-line request capture with encoded-index valid/ready output.
// Define REQ_ENC_ROUND_ROBIN_EN for round-robin instead of lowest-index-first.
module req_encoder16to4 #(
    parameter int NREQ = 16,
    parameter int IDXW = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req,
    input  logic            en,
    output logic            valid,
    input  logic            ready,
    output logic [IDXW-1:0] idx,
    output logic [NREQ-1:0] pending,
    output logic [IDXW:0]   pend_cnt,
    output logic            overrun
);

    typedef enum logic {IDLE, PRESENT} state_e;

    state_e          state_q;
    logic            valid_q;
    logic [IDXW-1:0] idx_q;
    logic [NREQ-1:0] pending_q;
    logic [NREQ-1:0] pending_d;
    logic [IDXW:0]   cnt_q;
    logic [IDXW:0]   cnt_d;
    logic            overrun_q;
    logic            overrun_d;

    logic            acc;
    logic [NREQ-1:0] clr;
    logic [NREQ-1:0] cand;
    logic [NREQ-1:0] setv;
    logic [IDXW-1:0] win;
    logic            found;

    assign acc  = valid_q & ready;
    assign setv = req & {NREQ{en}};

    always_comb begin
        clr = '0;
        if (acc) clr[idx_q] = 1'b1;
    end

    // A bit cleared and re-requested on the same edge stays pending
    assign cand      = pending_q & ~clr;
    assign pending_d = cand | setv;
    assign overrun_d = |(setv & cand);

    always_comb begin
        cnt_d = '0;
        for (int i = 0; i < NREQ; i++) begin
            cnt_d = cnt_d + {{IDXW{1'b0}}, pending_d[i]};
        end
    end

`ifdef REQ_ENC_ROUND_ROBIN_EN
    logic [IDXW-1:0] ptr_q;
    logic [IDXW-1:0] base;
    logic [IDXW-1:0] j;

    assign base = acc ? idx_q : ptr_q;

    always_comb begin
        win   = '0;
        found = 1'b0;
        j     = '0;
        for (int k = 1; k <= NREQ; k++) begin
            j = base + IDXW'(k);
            if (cand[j] && !found) begin
                win   = j;
                found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q <= '1;
        end else if (acc) begin
            ptr_q <= idx_q;
        end
    end
`else
    always_comb begin
        win   = '0;
        found = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (cand[i] && !found) begin
                win   = IDXW'(i);
                found = 1'b1;
            end
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            valid_q   <= 1'b0;
            idx_q     <= '0;
            pending_q <= '0;
            cnt_q     <= '0;
            overrun_q <= 1'b0;
        end else begin
            pending_q <= pending_d;
            cnt_q     <= cnt_d;
            overrun_q <= overrun_d;
            unique case (state_q)
                IDLE: begin
                    if (found) begin
                        idx_q   <= win;
                        valid_q <= 1'b1;
                        state_q <= PRESENT;
                    end
                end
                PRESENT: begin
                    if (ready) begin
                        if (found) begin
                            idx_q <= win;
                        end else begin
                            valid_q <= 1'b0;
                            state_q <= IDLE;
                        end
                    end
                end
            endcase
        end
    end

    assign valid    = valid_q;
    assign idx      = idx_q;
    assign pending  = pending_q;
    assign pend_cnt = cnt_q;
    assign overrun  = overrun_q;

endmodule

// File: tb/tb_req_encoder16to4.sv
// Scoreboard bench for req_encoder16to4: a behavioural model pushes the
// expected post-edge outputs, which are popped and compared after each edge.
module tb_req_encoder16to4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] req = '0;
    logic        en = 1'b0;
    logic        valid;
    logic        ready = 1'b0;
    logic [3:0]  idx;
    logic [15:0] pending;
    logic [4:0]  pend_cnt;
    logic        overrun;

    always #5 clk = ~clk;

    req_encoder16to4 dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .en       (en),
        .valid    (valid),
        .ready    (ready),
        .idx      (idx),
        .pending  (pending),
        .pend_cnt (pend_cnt),
        .overrun  (overrun)
    );

    typedef struct packed {
        logic        v;
        logic [3:0]  i;
        logic [15:0] p;
        logic [4:0]  c;
        logic        o;
    } exp_t;

    exp_t sbq[$];
    int   n_err = 0;
    int   n_chk = 0;

    logic [15:0] m_pend = '0;
    logic        m_v = 1'b0;
    logic [3:0]  m_i = '0;
    logic [3:0]  m_ptr = 4'hF;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_step();
        exp_t        x;
        logic        acc;
        logic        hit;
        logic [15:0] clr;
        logic [15:0] cand;
        logic [15:0] setv;
        logic [3:0]  w;
        int          pos;
        x = '0;
        if (!rst_n) begin
            m_pend = '0;
            m_v    = 1'b0;
            m_i    = '0;
            m_ptr  = 4'hF;
        end else begin
            acc  = m_v && ready;
            clr  = acc ? (16'h1 << m_i) : 16'h0;
            cand = m_pend & ~clr;
            setv = en ? req : 16'h0;
            x.o  = |(setv & m_pend & ~clr);
            hit  = 1'b0;
            w    = '0;
`ifdef REQ_ENC_ROUND_ROBIN_EN
            for (int k = 1; k <= 16; k++) begin
                pos = (int'(acc ? m_i : m_ptr) + k) % 16;
                if (!hit && cand[pos]) begin
                    w   = 4'(pos);
                    hit = 1'b1;
                end
            end
            if (acc) m_ptr = m_i;
`else
            for (int k = 0; k < 16; k++) begin
                pos = k;
                if (!hit && cand[pos]) begin
                    w   = 4'(pos);
                    hit = 1'b1;
                end
            end
`endif
            m_pend = cand | setv;
            if (!m_v) begin
                if (hit) begin
                    m_v = 1'b1;
                    m_i = w;
                end
            end else if (ready) begin
                if (hit) m_i = w;
                else m_v = 1'b0;
            end
        end
        x.v = m_v;
        x.i = m_i;
        x.p = m_pend;
        x.c = 5'($countones(m_pend));
        sbq.push_back(x);
    endtask

    task automatic step(input logic r, input logic e,
                        input logic [15:0] q, input logic rd);
        exp_t x;
        @(negedge clk);
        rst_n = r;
        en    = e;
        req   = q;
        ready = rd;
        model_step();
        @(posedge clk);
        #1;
        if (sbq.size() == 0) begin
            check("sb_underflow", 1, 0);
        end else begin
            x = sbq.pop_front();
            check("valid", valid, x.v);
            check("idx", idx, x.i);
            check("pending", pending, x.p);
            check("pend_cnt", pend_cnt, x.c);
            check("overrun", overrun, x.o);
        end
    endtask

    logic [3:0] rr_seq [4];

    initial begin
        rr_seq = '{4'd0, 4'd1, 4'd0, 4'd1};

        step(0, 1, 16'hFFFF, 1);
        step(0, 1, 16'hFFFF, 1);
        check("rst_valid", valid, 0);
        check("rst_pend", pending, 0);
        for (int i = 0; i < 5; i++) step(1, 1, 16'h0000, 0);

        step(1, 1, 16'h0400, 1);
        check("t2_pend", pending, 16'h0400);
        step(1, 1, 16'h0000, 1);
        check("t2_valid", valid, 1);
        check("t2_idx", idx, 10);
        step(1, 1, 16'h0000, 1);
        check("t2_drop", valid, 0);
        check("t2_clear", pending, 0);

        for (int i = 0; i < 3; i++) step(1, 0, 16'hFFFF, 0);
        check("t3_gate", pending, 0);
        step(1, 1, 16'h8001, 0);
        for (int i = 0; i < 4; i++) step(1, 1, 16'h0000, 0);
        check("t3_hold_idx", idx, 0);
        check("t3_hold_v", valid, 1);
        step(1, 1, 16'h0000, 1);
        check("t3_idx15", idx, 15);
        step(1, 1, 16'h0000, 1);
        check("t3_drop", valid, 0);

        step(1, 1, 16'h0001, 0);
        step(1, 1, 16'h0000, 0);
        step(1, 1, 16'h0001, 1);
        check("t4_setwins", pending, 16'h0001);
        check("t4_no_ovr", overrun, 0);
        step(1, 1, 16'h0000, 0);
        check("t4_again_v", valid, 1);
        check("t4_again_i", idx, 0);
        step(1, 1, 16'h0000, 1);

        step(1, 1, 16'h0020, 0);
        step(1, 1, 16'h0000, 0);
        step(1, 1, 16'h0020, 0);
        check("t5_ovr", overrun, 1);
        check("t5_cnt", pend_cnt, 1);
        step(1, 1, 16'h0000, 0);
        check("t5_ovr_off", overrun, 0);
        step(1, 1, 16'h0000, 1);

        step(1, 1, 16'h0003, 1);
        for (int i = 0; i < 4; i++) begin
            step(1, 1, 16'h0003, 1);
            check("t6_seq", idx, rr_seq[i]);
        end
        for (int i = 0; i < 3; i++) step(1, 1, 16'h0000, 1);

        step(1, 1, 16'hFFFF, 1);
        check("t7_cnt16", pend_cnt, 16);
        for (int i = 0; i < 18; i++) step(1, 1, 16'h0000, 1);
        check("t7_empty", valid, 0);

        step(1, 1, 16'h0030, 0);
        step(1, 1, 16'h0000, 0);
        step(0, 1, 16'h0000, 1);
        check("t8_rst_v", valid, 0);
        check("t8_rst_p", pending, 0);
        step(1, 1, 16'h0000, 1);

        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(0, 49) != 0),
                 1'($urandom_range(0, 3) != 0),
                 16'($urandom & $urandom & $urandom),
                 1'($urandom_range(0, 1)));
        end

        check("sb_empty", sbq.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
